fir_mac_scheduler: RTL

- Time-multiplexed 22-tap symmetric low-pass FIR engine shared between the RED and IR photodiode channels of the pulse-oximeter front end.
- Accepts 8-bit ADC samples per channel over valid/ready and keeps a separate 22-deep delay line per channel.
- A round-robin arbiter grants the single pre-add/multiply/accumulate unit to one channel at a time, then sequences the 11 symmetric taps over 11 cycles.
- Emits one tagged 20-bit filtered result per accepted sample.

---
 rtl/fir_mac_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fir_mac_scheduler.sv
// Shared 22-tap symmetric FIR for the RED/IR photodiode channels: one pre-add/MAC
// unit, round-robin granted per accepted sample, 11 cycles per result.
module fir_mac_scheduler #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 20
) (
    input  logic              CLK_Filter,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              red_valid,
    input  logic [DATA_W-1:0] red_data,
    output logic              red_ready,
    input  logic              ir_valid,
    input  logic [DATA_W-1:0] ir_data,
    output logic              ir_ready,
    output logic              out_valid,
    output logic              out_chan,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy
);
    localparam int unsigned NTAPS  = 22;
    localparam int unsigned NHALF  = 11;
    localparam int unsigned PRE_W  = DATA_W + 1;
    localparam int unsigned COEF_W = 8;
    localparam int unsigned PROD_W = PRE_W + COEF_W;
    localparam int unsigned K_W    = 4;
    localparam int unsigned IDX_W  = 5;
    localparam logic        CH_RED = 1'b0;
    localparam logic        CH_IR  = 1'b1;

    typedef enum logic {IDLE, MAC} state_t;

    state_t             state, state_d;
    logic [DATA_W-1:0]  dl [2][NTAPS];
    logic [DATA_W-1:0]  hold [2];
    logic [1:0]         pend;
    logic               last_grant;
    logic [OUT_W-1:0]   acc;
    logic [K_W-1:0]     k;

    logic               grant_c;
    logic               gnt_chan_c;
    logic               mac_c;
    logic               done_c;
    logic [IDX_W-1:0]   tap_idx_c;
    logic [IDX_W-1:0]   mirror_idx_c;
    logic [PRE_W-1:0]   pre_c;
    logic [PROD_W-1:0]  prod_c;
    logic [OUT_W-1:0]   acc_next_c;

    // Half of the symmetric impulse response; c[k] == c[21-k].
    function automatic logic [COEF_W-1:0] coef(input logic [K_W-1:0] idx);
        case (idx)
            4'd0:    coef = 8'd2;
            4'd1:    coef = 8'd10;
            4'd2:    coef = 8'd16;
            4'd3:    coef = 8'd28;
            4'd4:    coef = 8'd43;
            4'd5:    coef = 8'd60;
            4'd6:    coef = 8'd78;
            4'd7:    coef = 8'd95;
            4'd8:    coef = 8'd111;
            4'd9:    coef = 8'd122;
            4'd10:   coef = 8'd128;
            default: coef = 8'd0;
        endcase
    endfunction

    assign red_ready = ~pend[0];
    assign ir_ready  = ~pend[1];

    // During MAC, last_grant is the channel being filtered.
    always_comb begin
        tap_idx_c    = IDX_W'(k);
        mirror_idx_c = IDX_W'(NTAPS - 1) - tap_idx_c;
        pre_c        = PRE_W'(dl[last_grant][tap_idx_c]) + PRE_W'(dl[last_grant][mirror_idx_c]);
        prod_c       = PROD_W'(coef(k)) * PROD_W'(pre_c);
        acc_next_c   = acc + OUT_W'(prod_c);
    end

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d    = state;
        grant_c    = 1'b0;
        gnt_chan_c = last_grant;
        mac_c      = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (pend != 2'b00) begin
                    grant_c    = 1'b1;
                    gnt_chan_c = (pend == 2'b11) ? ~last_grant : pend[1];
                    state_d    = MAC;
                end
            end
            MAC: begin
                mac_c = 1'b1;
                if (k == K_W'(NHALF - 1)) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding slots, delay lines, accumulator and result registers.
    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                hold[c] <= '0;
                for (int i = 0; i < NTAPS; i++) dl[c][i] <= '0;
            end
            pend       <= 2'b00;
            last_grant <= CH_IR;
            acc        <= '0;
            k          <= '0;
            out_valid  <= 1'b0;
            out_chan   <= CH_RED;
            out_data   <= '0;
        end else if (clr) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < NTAPS; i++) dl[c][i] <= '0;
            end
            pend      <= 2'b00;
            acc       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (red_valid && !pend[0]) begin
                hold[0] <= red_data;
                pend[0] <= 1'b1;
            end
            if (ir_valid && !pend[1]) begin
                hold[1] <= ir_data;
                pend[1] <= 1'b1;
            end
            if (grant_c) begin
                dl[gnt_chan_c][0] <= hold[gnt_chan_c];
                for (int i = 1; i < NTAPS; i++) dl[gnt_chan_c][i] <= dl[gnt_chan_c][i-1];
                pend[gnt_chan_c] <= 1'b0;
                last_grant       <= gnt_chan_c;
                acc              <= '0;
                k                <= '0;
            end
            if (mac_c) begin
                acc <= acc_next_c;
                k   <= k + K_W'(1);
            end
            if (done_c) begin
                out_data  <= acc_next_c;
                out_chan  <= last_grant;
                out_valid <= 1'b1;
            end
        end
    end
endmodule
